// File: rtl/ofifo_if.sv
// Bus bundle between the MAC array south edge, the output FIFO and the psum SRAM writer.
// The slave modport is the FIFO itself.
interface ofifo_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16
);
  logic [psum_bw*col-1:0] in;
  logic [col-1:0]         wr;
  logic                   rd;
  logic [psum_bw*col-1:0] out;
  logic                   out_vld;
  logic                   o_valid;
  logic                   o_full;
  logic                   o_ready;
  logic                   o_overflow;

  modport master (
    output in, wr, rd,
    input  out, out_vld, o_valid, o_full, o_ready, o_overflow
  );

  modport slave (
    input  in, wr, rd,
    output out, out_vld, o_valid, o_full, o_ready, o_overflow
  );
endinterface

// File: rtl/ofifo.sv
// Output FIFO behind the MAC array: one circular buffer per column, filled independently,
// drained one aligned row at a time.
module ofifo #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input logic    clk,
  input logic    reset,
  ofifo_if.slave bus
);
  localparam int AW = $clog2(depth);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(depth);

  logic [psum_bw-1:0]     r_mem  [col][depth];
  logic [AW-1:0]          r_wptr [col];
  logic [AW-1:0]          r_rptr [col];
  logic [AW:0]            r_cnt  [col];
  logic [psum_bw*col-1:0] r_out;
  logic                   r_out_vld;
  logic                   r_overflow;

  logic           w_valid;
  logic           w_full;
  logic           w_pop;
  logic [col-1:0] w_wacc;
  logic [col-1:0] w_drop;

  // Flags come from registered counts only, so a write landing on an empty
  // column cannot be popped in the same cycle.
  always_comb begin
    w_valid = 1'b1;
    w_full  = 1'b0;
    for (int c = 0; c < col; c++) begin
      w_valid = w_valid & (r_cnt[c] != '0);
      w_full  = w_full  | (r_cnt[c] == DEPTH_C);
    end
  end

  assign w_pop = bus.rd & w_valid;

  always_comb begin
    w_wacc = '0;
    w_drop = '0;
    for (int c = 0; c < col; c++) begin
      w_wacc[c] = bus.wr[c] & ((r_cnt[c] != DEPTH_C) | w_pop);
      w_drop[c] = bus.wr[c] & ~w_wacc[c];
    end
  end

  // Storage is deliberately not reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    for (int c = 0; c < col; c++) begin
      if (!reset && w_wacc[c])
        r_mem[c][r_wptr[c]] <= bus.in[c*psum_bw +: psum_bw];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < col; c++) begin
        r_wptr[c] <= '0;
        r_rptr[c] <= '0;
        r_cnt[c]  <= '0;
      end
      r_out      <= '0;
      r_out_vld  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_out_vld <= w_pop;
      if (|w_drop)
        r_overflow <= 1'b1;
      for (int c = 0; c < col; c++) begin
        if (w_wacc[c])
          r_wptr[c] <= r_wptr[c] + AW'(1);
        if (w_pop) begin
          r_out[c*psum_bw +: psum_bw] <= r_mem[c][r_rptr[c]];
          r_rptr[c] <= r_rptr[c] + AW'(1);
        end
        case ({w_wacc[c], w_pop})
          2'b10:   r_cnt[c] <= r_cnt[c] + (AW+1)'(1);
          2'b01:   r_cnt[c] <= r_cnt[c] - (AW+1)'(1);
          default: r_cnt[c] <= r_cnt[c];
        endcase
      end
    end
  end

  assign bus.out        = r_out;
  assign bus.out_vld    = r_out_vld;
  assign bus.o_valid    = w_valid;
  assign bus.o_full     = w_full;
  assign bus.o_ready    = ~w_full;
  assign bus.o_overflow = r_overflow;
endmodule

// File: tb/tb_ofifo.sv
// Directed bench for ofifo: skewed fill, early read, full/overflow, pointer wrap, mid-stream reset.
module tb_ofifo;
  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int DEP = 64;
  localparam int W   = COL*BW;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  ofifo_if #(.col(COL), .psum_bw(BW)) u_if ();
  ofifo #(.col(COL), .psum_bw(BW), .depth(DEP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  always #5 clk = ~clk;

  // Row whose column c holds base + c*stride.
  function automatic logic [W-1:0] mk(input logic [15:0] base, input logic [15:0] stride);
    logic [W-1:0] r;
    r = '0;
    for (int c = 0; c < COL; c++)
      r[c*BW +: BW] = base + 16'(c) * stride;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    u_if.in = '0;
    u_if.wr = '0;
    u_if.rd = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    u_if.rd = 1'b0;
    tick();

    // 1: reset / idle
    chk1("rst_valid", u_if.o_valid, 1'b0);
    chk1("rst_full", u_if.o_full, 1'b0);
    chk1("rst_ready", u_if.o_ready, 1'b1);
    chk1("rst_outvld", u_if.out_vld, 1'b0);
    chk1("rst_ovf", u_if.o_overflow, 1'b0);
    chk("rst_out", u_if.out, '0);

    // 2: skewed diagonal fill
    u_if.in = mk(16'h0100, 16'h0001);
    for (int k = 0; k < COL; k++) begin
      u_if.wr = 8'((16'h1 << (k+1)) - 1);
      tick();
      chk1($sformatf("skew_valid_%0d", k), u_if.o_valid, (k == COL-1));
    end
    u_if.wr = '0;
    u_if.rd = 1'b1;
    tick();
    chk("skew_out", u_if.out, mk(16'h0100, 16'h0001));
    chk1("skew_outvld", u_if.out_vld, 1'b1);
    u_if.rd = 1'b0;
    tick();
    chk1("skew_outvld_drop", u_if.out_vld, 1'b0);
    chk("skew_out_hold", u_if.out, mk(16'h0100, 16'h0001));
    chk1("skew_col7_empty", u_if.o_valid, 1'b0);

    // 3: early rd is ignored
    do_reset();
    u_if.in = mk(16'h0300, 16'h0001);
    u_if.wr = 8'h01;
    tick();
    u_if.wr = '0;
    chk1("early_valid", u_if.o_valid, 1'b0);
    u_if.rd = 1'b1;
    tick();
    u_if.rd = 1'b0;
    chk1("early_outvld", u_if.out_vld, 1'b0);
    chk("early_out", u_if.out, '0);
    u_if.wr = 8'hFE;
    tick();
    u_if.wr = '0;
    chk1("early_valid2", u_if.o_valid, 1'b1);
    u_if.rd = 1'b1;
    tick();
    u_if.rd = 1'b0;
    chk("early_pop", u_if.out, mk(16'h0300, 16'h0001));
    chk1("early_empty", u_if.o_valid, 1'b0);

    // 4: full and overflow
    do_reset();
    u_if.wr = 8'hFF;
    for (int i = 0; i < DEP; i++) begin
      u_if.in = mk(16'(i), 16'h0100);
      tick();
      if (i == DEP-2) chk1("fill_notfull", u_if.o_full, 1'b0);
    end
    chk1("fill_full", u_if.o_full, 1'b1);
    chk1("fill_ready", u_if.o_ready, 1'b0);
    chk1("fill_ovf0", u_if.o_overflow, 1'b0);
    u_if.wr = 8'h01;
    u_if.in = {8{16'hDEAD}};
    tick();
    chk1("ovf_set", u_if.o_overflow, 1'b1);
    chk1("ovf_still_full", u_if.o_full, 1'b1);
    u_if.wr = 8'hFF;
    u_if.rd = 1'b1;
    u_if.in = mk(16'hE000, 16'h0001);
    tick();
    u_if.wr = '0;
    chk("full_rdwr_out", u_if.out, mk(16'h0000, 16'h0100));
    chk1("full_rdwr_full", u_if.o_full, 1'b1);
    for (int i = 1; i < DEP; i++) begin
      tick();
      chk($sformatf("drain_%0d", i), u_if.out, mk(16'(i), 16'h0100));
    end
    tick();
    u_if.rd = 1'b0;
    chk("drain_last", u_if.out, mk(16'hE000, 16'h0001));
    chk1("drain_empty", u_if.o_valid, 1'b0);
    chk1("ovf_sticky", u_if.o_overflow, 1'b1);

    // 5: wrap with streaming push/pop
    u_if.wr = 8'hFF;
    u_if.in = mk(16'h0000, 16'h0001);
    tick();
    u_if.rd = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      if (i == 200) u_if.wr = '0;
      else u_if.in = mk(16'(i*8), 16'h0001);
      tick();
      chk($sformatf("wrap_%0d", i-1), u_if.out, mk(16'((i-1)*8), 16'h0001));
    end
    u_if.rd = 1'b0;
    tick();
    chk1("wrap_empty", u_if.o_valid, 1'b0);
    chk1("wrap_outvld0", u_if.out_vld, 1'b0);

    // 6: reset mid-stream
    u_if.wr = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      u_if.in = mk(16'(16'h7000 + i*8), 16'h0001);
      tick();
    end
    chk1("mid_valid", u_if.o_valid, 1'b1);
    reset = 1'b1;
    u_if.rd = 1'b1;
    u_if.in = {8{16'hBAD0}};
    tick();
    reset = 1'b0;
    u_if.rd = 1'b0;
    u_if.wr = '0;
    chk1("mid_rst_valid", u_if.o_valid, 1'b0);
    chk1("mid_rst_outvld", u_if.out_vld, 1'b0);
    chk1("mid_rst_ovf", u_if.o_overflow, 1'b0);
    chk("mid_rst_out", u_if.out, '0);
    u_if.wr = 8'hFF;
    u_if.in = mk(16'hA5A0, 16'h0001);
    tick();
    u_if.wr = '0;
    u_if.rd = 1'b1;
    tick();
    u_if.rd = 1'b0;
    chk("post_rst_row", u_if.out, mk(16'hA5A0, 16'h0001));
    chk1("post_rst_outvld", u_if.out_vld, 1'b1);
    chk1("post_rst_empty", u_if.o_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
